// File: rtl/serial_adder.sv
// Bit-serial adder/subtractor: one full-adder stage per clock, LSB first.
// A+B+Cin (SUB=0) or A-B-Cin (SUB=1) over WIDTH cycles, with a one-cycle DONE pulse.
// Optional feature: define SERIAL_ADDER_OVF_EN to add the OVF port, which reports signed overflow.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             SUB,
  output logic             BUSY,
  output logic [WIDTH-1:0] SUM,
  output logic             COUT,
  output logic             DONE
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             OVF
`endif
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t           state_q, state_d;
  logic             load, step, last;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, r_q, r_next;
  logic             carry_q;
  logic             s_bit, c_bit;

  // One full-adder stage; returns {carry_out, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic c);
    full_add = {(x & y) | (x & c) | (y & c), x ^ y ^ c};
  endfunction

  assign last = (cnt_q == CW'(WIDTH - 1));
  assign {c_bit, s_bit} = full_add(a_q[0], b_q[0], carry_q);
  // New sum bit enters at the MSB, so after WIDTH shifts bit 0 sits at the LSB.
  assign r_next = (r_q >> 1) | (WIDTH'(s_bit) << (WIDTH - 1));

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state and control decode; START is only honoured in IDLE or FIN.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    BUSY    = 1'b0;
    DONE    = 1'b0;
    case (state_q)
      IDLE: begin
        if (START) begin
          load    = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        BUSY = 1'b1;
        step = 1'b1;
        if (last) state_d = FIN;
      end
      FIN: begin
        DONE = 1'b1;
        if (START) begin
          load    = 1'b1;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, per-bit shifting and publication of the finished result.
  // Subtraction is A + ~B + ~Cin, so the inversion happens once at capture time.
  always_ff @(posedge CLK) begin
    if (RST) begin
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      SUM     <= '0;
      COUT    <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      OVF     <= 1'b0;
`endif
    end else if (load) begin
      a_q     <= A;
      b_q     <= B ^ {WIDTH{SUB}};
      carry_q <= Cin ^ SUB;
      r_q     <= '0;
      cnt_q   <= '0;
    end else if (step) begin
      a_q     <= a_q >> 1;
      b_q     <= b_q >> 1;
      r_q     <= r_next;
      carry_q <= c_bit;
      cnt_q   <= last ? '0 : cnt_q + CW'(1);
      if (last) begin
        SUM  <= r_next;
        COUT <= c_bit;
`ifdef SERIAL_ADDER_OVF_EN
        // carry_q is still the carry into the MSB stage here.
        OVF  <= carry_q ^ c_bit;
`endif
      end
    end
  end

endmodule

// File: doc/serial_adder.md
SERIAL_ADDER -- requirements
Module: serial_adder

Interface
REQ-001 Parameter: WIDTH, default 8, operand/result width in bits; legal range 1..64.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 RST  input  1  synchronous, active-high reset.
REQ-004 START  input  1  request to begin an operation; sampled only when accepted (REQ-010).
REQ-005 A  input  WIDTH  first operand; captured on accepted START.
REQ-006 B  input  WIDTH  second operand; captured on accepted START.
REQ-007 Cin  input  1  carry-in (SUB=0) or borrow-in (SUB=1); captured on accepted START.
REQ-008 SUB  input  1  mode: 0 = A+B+Cin, 1 = A-B-Cin; captured on accepted START.
REQ-009 BUSY  output 1  high while bit-serial computation runs; SUM  output WIDTH  last completed result; COUT  output 1  last completed carry-out; DONE  output 1  one-cycle completion pulse.

Function
REQ-010 FSM states IDLE, RUN, FIN; START accepted only in IDLE or FIN; START in RUN ignored with no effect.
REQ-011 Accepted START: latch A, B^{WIDTH{SUB}}, carry = Cin^SUB, clear bit counter, next state RUN.
REQ-012 RUN: one full-adder stage per cycle, LSB first; bit i processed on i-th RUN edge; carry flip-flop holds inter-bit carry.
REQ-013 RUN lasts exactly WIDTH cycles; BUSY=1 for exactly those cycles; counter wraps nowhere (terminal count = WIDTH-1 exits to FIN).
REQ-014 On edge leaving RUN: SUM <= assembled result, COUT <= final carry; state FIN; DONE=1 for that one cycle only.
REQ-015 FIN with START=0 -> IDLE; FIN with START=1 -> RUN (back-to-back, no idle cycle).
REQ-016 SUM/COUT change only on the RUN->FIN edge or reset; stable during RUN and IDLE.
REQ-017 SUB=1: COUT=1 means no borrow, COUT=0 means borrow; SUM is modulo 2^WIDTH.
REQ-018 WIDTH=1: RUN lasts one cycle; behaviour equals a registered full adder with DONE one cycle after START.
REQ-019 Operand inputs changing after acceptance have no effect on the running operation.

Reset
REQ-020 RST=1 at a rising edge: state IDLE, BUSY=0, DONE=0, SUM=0, COUT=0, counter/carry/shift registers 0.
REQ-021 RST dominates START in the same cycle; RST mid-RUN aborts, no DONE issued, SUM/COUT read 0.
REQ-022 First START accepted on the first edge with RST=0.

Configuration
REQ-023 Macro SERIAL_ADDER_OVF_EN defined: extra port OVF  output 1  signed overflow = carry into MSB XOR final carry; updated with SUM, reset 0.
REQ-024 Macro undefined: no OVF port, no MSB-carry register; all other behaviour identical.

Verification
REQ-025 WIDTH=8, A=0x0F B=0x01 Cin=0 SUB=0 -> BUSY high 8 cycles, DONE pulse on 9th edge after START, SUM=0x10 COUT=0.
REQ-026 A=0xFF B=0x01 Cin=1 SUB=0 -> SUM=0x01 COUT=1; SUB=1 A=0x05 B=0x07 Cin=0 -> SUM=0xFE COUT=0; A=0x07 B=0x05 -> SUM=0x02 COUT=1.
REQ-027 START re-pulsed mid-RUN with A=0xAA B=0x55 -> ignored, first result reported; START held high in FIN cycle -> new RUN begins next cycle, BUSY continuous.
REQ-028 RST asserted on 3rd RUN cycle -> next cycle BUSY=0 SUM=0 COUT=0, no DONE; following START completes normally.
REQ-029 WIDTH=1 all 16 combinations of A,B,Cin,SUB -> SUM/COUT match truth table one cycle after START.
REQ-030 SERIAL_ADDER_OVF_EN defined, A=0x7F B=0x01 SUB=0 -> OVF=1; A=0x80 B=0x01 SUB=1 -> OVF=1; A=0x10 B=0x01 -> OVF=0; macro undefined -> build without OVF port passes REQ-025..REQ-029.
